seq_comparator: RTL and testbench



---
 rtl/seq_comparator.sv | 115 +++++++++++
 tb/tb_seq_comparator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: captures two operands on start and compares
// them CHUNK bits per cycle from the MS end, stopping at the first differing chunk.
module seq_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4,
  localparam int unsigned NCHUNK = WIDTH / CHUNK,
  localparam int unsigned IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic [IDXW-1:0]  diff_idx
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;
  logic [IDXW-1:0]  r_k;
  logic             r_busy;
  logic             r_done;
  logic             r_eq;
  logic             r_lt;
  logic             r_gt;
  logic [IDXW-1:0]  r_idx;

  logic [31:0]      w_shift;
  logic [CHUNK-1:0] w_flip;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_last;

  // Current chunk, with the sign bit of the MS chunk inverted in signed mode
  // so an unsigned chunk compare yields the two's-complement ordering.
  assign w_shift = (32'(NCHUNK) - 32'd1 - 32'(r_k)) * 32'(CHUNK);
  assign w_flip  = (r_sgn && (r_k == '0)) ? MSB_MASK : '0;
  assign w_ca    = CHUNK'(r_a >> w_shift) ^ w_flip;
  assign w_cb    = CHUNK'(r_b >> w_shift) ^ w_flip;
  assign w_last  = (r_k == IDXW'(NCHUNK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sgn   <= 1'b0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sgn   <= signed_mode;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_ca != w_cb) begin
            r_eq    <= 1'b0;
            r_lt    <= (w_ca < w_cb);
            r_gt    <= (w_ca > w_cb);
            r_idx   <= r_k;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_eq    <= 1'b1;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
            r_idx   <= r_k;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_k <= r_k + IDXW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign eq       = r_eq;
  assign lt       = r_lt;
  assign gt       = r_gt;
  assign diff_idx = r_idx;

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator (WIDTH=16, CHUNK=4): hand-computed vectors,
// handshake corner cases, async reset mid-compare, and a boundary/random sweep.
module tb_seq_comparator;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = 2;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             eq;
  logic             lt;
  logic             gt;
  logic [IDXW-1:0]  diff_idx;

  int n_checks = 0;
  int n_errors = 0;

  seq_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .busy(busy), .done(done),
    .eq(eq), .lt(lt), .gt(gt), .diff_idx(diff_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a start for one edge; returns just after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic s);
    @(negedge clk);
    start = 1'b1; a = va; b = vb; signed_mode = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycles from the accepting edge to the edge that raises done (bounded).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
  endtask

  function automatic int first_diff(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    for (int k = 0; k < int'(NCHUNK); k++)
      if (va[WIDTH-1-k*CHUNK -: CHUNK] != vb[WIDTH-1-k*CHUNK -: CHUNK]) return k;
    return int'(NCHUNK) - 1;
  endfunction

  task automatic run_model(input string tag, input logic [WIDTH-1:0] va,
                           input logic [WIDTH-1:0] vb, input logic s);
    int lat;
    int d;
    logic xl, xg;
    d  = first_diff(va, vb);
    xl = s ? ($signed(va) < $signed(vb)) : (va < vb);
    xg = s ? ($signed(va) > $signed(vb)) : (va > vb);
    issue(va, vb, s);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(d + 1));
    chk({tag, "_res"}, {29'd0, eq, lt, gt}, {29'd0, ~(xl | xg), xl, xg});
    chk({tag, "_idx"}, 32'(diff_idx), 32'(d));
    chk({tag, "_onehot"}, 32'($countones({eq, lt, gt})), 32'd1);
  endtask

  logic [WIDTH-1:0] bnd [8];
  int lat;

  initial begin
    bnd = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h7FFE, 16'h8001, 16'hFFFE};
    rst = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {26'd0, busy, done, eq, lt, gt, diff_idx},
        32'd0);
    @(negedge clk); rst = 1'b0;

    // 5 vs 6: MS three chunks equal, decided in chunk 3
    issue(16'd5, 16'd6, 1'b0);
    chk("a5b6_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("a5b6_lat", 32'(lat), 32'd4);
    chk("a5b6_res", {29'd0, eq, lt, gt}, 32'b010);
    chk("a5b6_idx", 32'(diff_idx), 32'd3);
    @(posedge clk); #1;
    chk("a5b6_done_pulse", 32'(done), 32'd0);
    chk("a5b6_hold", {29'd0, eq, lt, gt}, 32'b010);

    // 8000 vs 0001 decided in chunk 0, opposite answers per mode
    issue(16'h8000, 16'h0001, 1'b0);
    wait_done(lat);
    chk("u8000_lat", 32'(lat), 32'd1);
    chk("u8000_res", {29'd0, eq, lt, gt}, 32'b001);
    chk("u8000_idx", 32'(diff_idx), 32'd0);
    issue(16'h8000, 16'h0001, 1'b1);
    wait_done(lat);
    chk("s8000_lat", 32'(lat), 32'd1);
    chk("s8000_res", {29'd0, eq, lt, gt}, 32'b010);
    chk("s8000_idx", 32'(diff_idx), 32'd0);

    // Equal, then back-to-back start raised in the done cycle
    issue(16'd5, 16'd5, 1'b0);
    wait_done(lat);
    chk("eq5_lat", 32'(lat), 32'd4);
    chk("eq5_res", {29'd0, eq, lt, gt}, 32'b100);
    chk("eq5_idx", 32'(diff_idx), 32'd3);
    chk("eq5_busy_in_done", 32'(busy), 32'd0);
    start = 1'b1; a = 16'd6; b = 16'd5; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accepted", 32'(busy), 32'd1);
    chk("b2b_hold_eq", {29'd0, eq, lt, gt}, 32'b100);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'd4);
    chk("b2b_res", {29'd0, eq, lt, gt}, 32'b001);

    // Start pulses while busy must be ignored
    issue(16'h1234, 16'h1235, 1'b0);
    start = 1'b1; a = 16'h0000; b = 16'hFFFF;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      if (n == 2) start = 1'b0;
      chk("busy_ign_nodone", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    chk("busy_ign_done", 32'(done), 32'd1);
    chk("busy_ign_res", {29'd0, eq, lt, gt}, 32'b010);
    chk("busy_ign_idx", 32'(diff_idx), 32'd3);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("busy_ign_single", {30'd0, busy, done}, 32'd0);
    end

    // Async reset between edges, mid-compare
    issue(16'hAAAA, 16'hAAAA, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid", {26'd0, busy, done, eq, lt, gt, diff_idx}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      chk("rst_no_done", {30'd0, busy, done}, 32'd0);
    end
    run_model("post_rst", 16'h0F00, 16'h0E00, 1'b0);

    // Boundary grid, both modes
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int s = 0; s < 2; s++)
          run_model("bnd", bnd[i], bnd[j], s[0]);

    // Random sweep; some pairs share high chunks to exercise late decisions
    for (int it = 0; it < 1000; it++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (it % 3 == 1) rb = {ra[15:8], rb[7:0]};
      if (it % 3 == 2) rb = {ra[15:4], rb[3:0]};
      run_model("rnd", ra, rb, 1'(it % 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
